// File: rtl/pwm_duty_scheduler.sv
// pwm_duty_scheduler: buffers software duty writes in per-channel shadow registers
// and commits each one to its PWM channel only while that channel's counter sits at
// START (the period right after rollover), one channel at a time, round-robin.
module pwm_duty_scheduler #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned START = 65535,
  parameter int unsigned NCH   = 4,
  parameter int unsigned AW    = 2
) (
  input  logic                 sysclk,
  input  logic                 sysreset,
  input  logic                 wr_en_i,
  input  logic [AW-1:0]        wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic [NCH*WIDTH-1:0] cnt_flat_i,
  input  logic                 ovr_clear_i,
  output logic [WIDTH-1:0]     load_data_o,
  output logic [NCH-1:0]       load_en_o,
  output logic [NCH-1:0]       pending_o,
  output logic [NCH-1:0]       overrun_o,
  output logic                 busy_o
);

  localparam logic [WIDTH-1:0] StartVal = WIDTH'(START);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StLoad = 2'd1;
  localparam logic [1:0] StGap  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [WIDTH-1:0] shadow_q [NCH];
  logic [NCH-1:0]   pending_q, pending_d;
  logic [NCH-1:0]   overrun_q, overrun_d;
  logic [NCH-1:0]   load_en_q, load_en_d;
  logic [WIDTH-1:0] load_data_q, load_data_d;
  logic [AW-1:0]    rr_ptr_q, rr_ptr_d;
  logic             busy_q, busy_d;

  logic [NCH-1:0]   eligible;
  logic             grant_found;
  logic             grant_valid;
  logic [AW-1:0]    grant_idx;
  logic [AW-1:0]    search_idx;
  logic [NCH-1:0]   grant_oh;
  logic             wr_hit;
  logic [NCH-1:0]   wr_oh;

  // Eligibility: a value is waiting and the live counter is in its safe window.
  always_comb begin
    eligible = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      eligible[k] = pending_q[k] && (cnt_flat_i[k*WIDTH +: WIDTH] == StartVal);
    end
  end

  // Round-robin search from rr_ptr upward with wrap; first eligible channel wins.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    search_idx  = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      search_idx = AW'((32'(rr_ptr_q) + i) % NCH);
      if (!grant_found && eligible[search_idx]) begin
        grant_found = 1'b1;
        grant_idx   = search_idx;
      end
    end
  end

  assign grant_valid = (state_q == StIdle) && grant_found;
  assign grant_oh    = grant_valid ? (NCH'(1) << grant_idx) : '0;
  assign wr_hit      = wr_en_i && (32'(wr_addr_i) < NCH);
  assign wr_oh       = wr_hit ? (NCH'(1) << wr_addr_i) : '0;

  // Next-state for flags, load bus, pointer and FSM.
  always_comb begin
    // A write to the channel being granted re-arms pending and is not an overrun.
    pending_d   = (pending_q & ~grant_oh) | wr_oh;
    // Clear first so a coincident overrun-setting write still wins.
    overrun_d   = (ovr_clear_i ? '0 : overrun_q) | (wr_oh & pending_q & ~grant_oh);
    load_en_d   = grant_oh;
    load_data_d = grant_valid ? shadow_q[grant_idx] : load_data_q;
    rr_ptr_d    = grant_valid ? AW'((32'(grant_idx) + 1) % NCH) : rr_ptr_q;
    state_d     = state_q;
    unique case (state_q)
      StIdle:  if (grant_valid) state_d = StLoad;
      StLoad:  state_d = StGap;
      StGap:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
    busy_d = (state_d != StIdle);
  end

  // Control and output registers.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      state_q     <= StIdle;
      pending_q   <= '0;
      overrun_q   <= '0;
      load_en_q   <= '0;
      load_data_q <= '0;
      rr_ptr_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      overrun_q   <= overrun_d;
      load_en_q   <= load_en_d;
      load_data_q <= load_data_d;
      rr_ptr_q    <= rr_ptr_d;
      busy_q      <= busy_d;
    end
  end

  // Shadow registers; the latest write always wins.
  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset) begin
      for (int unsigned k = 0; k < NCH; k++) begin
        shadow_q[k] <= '0;
      end
    end else if (wr_hit) begin
      shadow_q[wr_addr_i] <= wr_data_i;
    end
  end

  assign load_data_o = load_data_q;
  assign load_en_o   = load_en_q;
  assign pending_o   = pending_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_pwm_duty_scheduler.sv
// Bench for pwm_duty_scheduler: expected commits are queued when writes are issued
// and popped by a monitor whenever a load strobe appears.
module tb_pwm_duty_scheduler;

  localparam logic [15:0] START = 16'hFFFF;

  logic        sysclk;
  logic        sysreset;
  logic        wr_en;
  logic [1:0]  wr_addr;
  logic [15:0] wr_data;
  logic [63:0] cnt_flat;
  logic        ovr_clear;
  logic [15:0] load_data;
  logic [3:0]  load_en;
  logic [3:0]  pending;
  logic [3:0]  overrun;
  logic        busy;

  logic [15:0] cnt [4];
  assign cnt_flat = {cnt[3], cnt[2], cnt[1], cnt[0]};

  pwm_duty_scheduler #(
    .WIDTH(16),
    .START(65535),
    .NCH  (4),
    .AW   (2)
  ) dut (
    .sysclk     (sysclk),
    .sysreset   (sysreset),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .wr_data_i  (wr_data),
    .cnt_flat_i (cnt_flat),
    .ovr_clear_i(ovr_clear),
    .load_data_o(load_data),
    .load_en_o  (load_en),
    .pending_o  (pending),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    int          ch;
    logic [15:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   load_cyc_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   n_loads  = 0;
  int   cyc      = 0;
  logic prev_le  = 1'b0;

  always @(posedge sysclk) cyc <= cyc + 1;

  // Scoreboard monitor: each strobe must match the oldest expected commit.
  always @(negedge sysclk) begin
    exp_t e;
    logic [3:0] exp_oh;
    if (!sysreset && load_en != 4'b0) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_load: load_en=%b data=%h, required no load", load_en,
                 load_data);
      end else begin
        e = exp_q.pop_front();
        exp_oh = 4'b0001 << e.ch;
        if (load_en !== exp_oh || load_data !== e.data) begin
          n_fail++;
          $display("FAIL load_match: load_en=%b data=%h, required load_en=%b data=%h",
                   load_en, load_data, exp_oh, e.data);
        end
      end
      n_checks++;
      if (prev_le) begin
        n_fail++;
        $display("FAIL load_width: load_en=%b high on consecutive cycles, required one cycle",
                 load_en);
      end
      load_cyc_q.push_back(cyc);
      n_loads++;
    end
    prev_le = !sysreset && (load_en != 4'b0);
  end

  task automatic sync();
    @(posedge sysclk);
    #1;
  endtask

  // Drives a write captured on the next rising edge; returns 1 ns after that edge.
  task automatic do_write(input int ch, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = 2'(ch);
    wr_data = d;
    @(posedge sysclk);
    #1;
    wr_en = 1'b0;
  endtask

  task automatic test_reset();
    sysreset = 1'b1;
    repeat (3) @(posedge sysclk);
    @(negedge sysclk);
    sysreset = 1'b0;
    @(negedge sysclk);
    n_checks++;
    if (load_en !== 4'b0 || load_data !== 16'h0) begin
      n_fail++;
      $display("FAIL reset_load: load_en=%b data=%h, required 0000 0000", load_en, load_data);
    end
    n_checks++;
    if (pending !== 4'b0 || overrun !== 4'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: pending=%b overrun=%b busy=%b, required 0000 0000 0",
               pending, overrun, busy);
    end
  endtask

  task automatic test_single();
    sync();
    cnt[0] = START;
    exp_q.push_back('{ch: 0, data: 16'h1234});
    do_write(0, 16'h1234);
    @(negedge sysclk);
    n_checks++;
    if (load_en !== 4'b0 || pending !== 4'b0001) begin
      n_fail++;
      $display("FAIL single_pre: load_en=%b pending=%b, required 0000 0001", load_en, pending);
    end
    @(negedge sysclk);
    n_checks++;
    if (load_en !== 4'b0001 || load_data !== 16'h1234 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_load: load_en=%b data=%h busy=%b, required 0001 1234 1",
               load_en, load_data, busy);
    end
    @(negedge sysclk);
    n_checks++;
    if (load_en !== 4'b0 || pending !== 4'b0 || overrun !== 4'b0 || load_data !== 16'h1234) begin
      n_fail++;
      $display("FAIL single_post: load_en=%b pending=%b overrun=%b data=%h, required 0 0 0 1234",
               load_en, pending, overrun, load_data);
    end
    sync();
    cnt[0] = 16'd100;
    repeat (3) sync();
  endtask

  task automatic test_wait_rollover();
    int base;
    int k;
    logic early;
    sync();
    cnt[1] = 16'd100;
    exp_q.push_back('{ch: 1, data: 16'h0800});
    do_write(1, 16'h0800);
    base  = n_loads;
    early = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge sysclk);
      if (load_en != 4'b0 || pending[1] !== 1'b1) early = 1'b1;
    end
    n_checks++;
    if (early || n_loads != base) begin
      n_fail++;
      $display("FAIL rollover_hold: loads=%0d pending=%b, required 0 loads pending[1]=1",
               n_loads - base, pending);
    end
    sync();
    cnt[1] = 16'd0;
    sync();
    cnt[1] = START;
    k = 0;
    while (n_loads == base && k < 2) begin
      @(negedge sysclk);
      #1;
      k++;
    end
    n_checks++;
    if (n_loads == base) begin
      n_fail++;
      $display("FAIL rollover_load: no load within 2 cycles, required a load on ch1");
    end
    @(negedge sysclk);
    n_checks++;
    if (pending[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL rollover_pending: pending=%b, required pending[1]=0", pending);
    end
    sync();
    cnt[1] = 16'd100;
    repeat (3) sync();
  endtask

  task automatic test_round_robin();
    int base;
    int k;
    int c [4];
    sync();
    for (int ch = 0; ch < 4; ch++) do_write(ch, 16'h0A00 + 16'(ch));
    exp_q.push_back('{ch: 2, data: 16'h0A02});
    exp_q.push_back('{ch: 3, data: 16'h0A03});
    exp_q.push_back('{ch: 0, data: 16'h0A00});
    exp_q.push_back('{ch: 1, data: 16'h0A01});
    load_cyc_q.delete();
    base = n_loads;
    for (int ch = 0; ch < 4; ch++) cnt[ch] = START;
    k = 0;
    while (n_loads < base + 4 && k < 20) begin
      @(negedge sysclk);
      #1;
      k++;
    end
    n_checks++;
    if (n_loads < base + 4) begin
      n_fail++;
      $display("FAIL rr_count: loads=%0d, required 4", n_loads - base);
    end else begin
      for (int i = 0; i < 4; i++) c[i] = load_cyc_q[i];
      n_checks++;
      if (c[1] - c[0] != 3 || c[2] - c[1] != 3 || c[3] - c[2] != 3) begin
        n_fail++;
        $display("FAIL rr_spacing: gaps=%0d,%0d,%0d, required 3,3,3",
                 c[1] - c[0], c[2] - c[1], c[3] - c[2]);
      end
    end
    repeat (3) @(negedge sysclk);
    n_checks++;
    if (busy !== 1'b0 || pending !== 4'b0) begin
      n_fail++;
      $display("FAIL rr_idle: busy=%b pending=%b, required 0 0000", busy, pending);
    end
    sync();
    for (int ch = 0; ch < 4; ch++) cnt[ch] = 16'd100;
    repeat (3) sync();
  endtask

  task automatic test_overrun();
    int base;
    int k;
    sync();
    cnt[2] = 16'd100;
    do_write(2, 16'd5);
    do_write(2, 16'd9);
    @(negedge sysclk);
    n_checks++;
    if (overrun !== 4'b0100 || pending !== 4'b0100) begin
      n_fail++;
      $display("FAIL ovr_set: overrun=%b pending=%b, required 0100 0100", overrun, pending);
    end
    exp_q.push_back('{ch: 2, data: 16'd9});
    base = n_loads;
    sync();
    cnt[2] = START;
    k = 0;
    while (n_loads == base && k < 4) begin
      @(negedge sysclk);
      #1;
      k++;
    end
    n_checks++;
    if (n_loads == base || overrun !== 4'b0100) begin
      n_fail++;
      $display("FAIL ovr_commit: loads=%0d overrun=%b, required 1 load overrun=0100",
               n_loads - base, overrun);
    end
    sync();
    cnt[2] = 16'd100;
    ovr_clear = 1'b1;
    sync();
    ovr_clear = 1'b0;
    @(negedge sysclk);
    n_checks++;
    if (overrun !== 4'b0) begin
      n_fail++;
      $display("FAIL ovr_clear: overrun=%b, required 0000", overrun);
    end
    // Clear and set on the same edge: the set must stick.
    sync();
    do_write(2, 16'd1);
    ovr_clear = 1'b1;
    do_write(2, 16'd2);
    ovr_clear = 1'b0;
    @(negedge sysclk);
    n_checks++;
    if (overrun !== 4'b0100) begin
      n_fail++;
      $display("FAIL ovr_set_wins: overrun=%b, required 0100", overrun);
    end
    exp_q.push_back('{ch: 2, data: 16'd2});
    base = n_loads;
    sync();
    cnt[2] = START;
    k = 0;
    while (n_loads == base && k < 4) begin
      @(negedge sysclk);
      #1;
      k++;
    end
    n_checks++;
    if (n_loads == base) begin
      n_fail++;
      $display("FAIL ovr_commit2: no load, required load of ch2=0002");
    end
    sync();
    cnt[2] = 16'd100;
    ovr_clear = 1'b1;
    sync();
    ovr_clear = 1'b0;
    repeat (3) sync();
  endtask

  task automatic test_grant_edge_write();
    int base;
    int k;
    sync();
    cnt[0] = 16'd100;
    do_write(0, 16'd3);
    exp_q.push_back('{ch: 0, data: 16'd3});
    exp_q.push_back('{ch: 0, data: 16'd7});
    load_cyc_q.delete();
    base = n_loads;
    cnt[0] = START;
    do_write(0, 16'd7);
    @(negedge sysclk);
    n_checks++;
    if (load_en !== 4'b0001 || load_data !== 16'd3 || pending[0] !== 1'b1 || overrun !== 4'b0) begin
      n_fail++;
      $display("FAIL grant_edge: load_en=%b data=%h pending=%b overrun=%b, required 0001 0003 xxx1 0000",
               load_en, load_data, pending, overrun);
    end
    k = 0;
    while (n_loads < base + 2 && k < 6) begin
      @(negedge sysclk);
      #1;
      k++;
    end
    n_checks++;
    if (n_loads < base + 2) begin
      n_fail++;
      $display("FAIL grant_edge_second: loads=%0d, required 2", n_loads - base);
    end else if (load_cyc_q[1] - load_cyc_q[0] != 3) begin
      n_fail++;
      $display("FAIL grant_edge_gap: gap=%0d, required 3", load_cyc_q[1] - load_cyc_q[0]);
    end
    @(negedge sysclk);
    n_checks++;
    if (pending !== 4'b0 || overrun !== 4'b0) begin
      n_fail++;
      $display("FAIL grant_edge_post: pending=%b overrun=%b, required 0000 0000", pending, overrun);
    end
    sync();
    cnt[0] = 16'd100;
    repeat (3) sync();
  endtask

  task automatic test_reset_during_load();
    int base;
    int k;
    sync();
    cnt[1] = 16'd100;
    do_write(1, 16'h0055);
    cnt[3] = START;
    exp_q.push_back('{ch: 3, data: 16'hABCD});
    base = n_loads;
    do_write(3, 16'hABCD);
    k = 0;
    while (n_loads == base && k < 4) begin
      @(negedge sysclk);
      #1;
      k++;
    end
    n_checks++;
    if (load_en !== 4'b1000) begin
      n_fail++;
      $display("FAIL rst_load_pre: load_en=%b, required 1000", load_en);
    end
    sysreset = 1'b1;
    #1;
    n_checks++;
    if (load_en !== 4'b0 || load_data !== 16'h0 || pending !== 4'b0 || overrun !== 4'b0 ||
        busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_load: load_en=%b data=%h pending=%b overrun=%b busy=%b, required all 0",
               load_en, load_data, pending, overrun, busy);
    end
    @(negedge sysclk);
    sysreset = 1'b0;
    base = n_loads;
    sync();
    cnt[1] = START;
    repeat (6) sync();
    n_checks++;
    if (n_loads != base || pending !== 4'b0) begin
      n_fail++;
      $display("FAIL rst_no_replay: loads=%0d pending=%b, required 0 0000", n_loads - base,
               pending);
    end
  endtask

  initial begin
    sysreset  = 1'b1;
    wr_en     = 1'b0;
    wr_addr   = '0;
    wr_data   = '0;
    ovr_clear = 1'b0;
    for (int ch = 0; ch < 4; ch++) cnt[ch] = 16'd100;

    test_reset();
    test_single();
    test_wait_rollover();
    test_round_robin();
    test_overrun();
    test_grant_edge_write();
    test_reset_during_load();

    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover: %0d expected loads never seen, required 0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_duty_scheduler.md
# pwm_duty_scheduler

Sequences duty-cycle updates into a bank of NCH countdown PWM channels that share one duty data bus. Software writes new duty values into per-channel shadow registers at any time. The scheduler commits each value to its channel only inside that channel's safe window, the count period right after rollover when the counter holds START. This keeps software duty changes from glitching the PWM outputs. It sits between the CPU register bus and the PWM channels' duty_load/data_in ports.

## Interface
- WIDTH, 16: counter/duty width; must match the PWM channels.
- START, 65535: channel reload value; must match the PWM channels.
- NCH, 4: number of PWM channels, 1..16.
- AW, 2: write address width, ≥ clog2(NCH).

- sysclk  in  1  system clock; all logic rising-edge.
- sysreset  in  1  reset, asynchronous, active-high.
- wr_en  in  1  one-cycle write strobe for a shadow register.
- wr_addr  in  AW  channel index for the write.
- wr_data  in  WIDTH  new duty value.
- cnt_flat  in  NCH*WIDTH  channel counter values; channel k occupies bits [k*WIDTH +: WIDTH].
- load_data  out  WIDTH  duty bus to all channels' data_in; registered.
- load_en  out  NCH  one-hot duty_load strobes; registered.
- pending  out  NCH  per-channel flag: a shadow value is waiting to be committed.
- overrun  out  NCH  sticky flag: a pending value was overwritten before it was committed.
- ovr_clear  in  1  one-cycle pulse that clears all overrun bits.
- busy  out  1  high while the FSM is not in IDLE.

## Operation
- **Shadow write.** On an edge with wr_en=1 and wr_addr<NCH: shadow[wr_addr] ← wr_data and pending[wr_addr] ← 1. Writes with wr_addr≥NCH are ignored.
- **Overrun.** If that write hits a channel whose pending bit is already 1 and the channel is not being granted on the same edge, overrun[wr_addr] ← 1. The latest value wins.
- **Eligibility.** Channel k is eligible when pending[k]=1 and cnt_k==START. Eligibility is combinational from registered pending and live cnt_flat.
- **FSM states: IDLE, LOAD, GAP.**
  - IDLE: if any channel is eligible, grant the channel chosen by round-robin and go to LOAD. On the grant edge: load_data ← shadow[k], load_en ← one-hot(k), pending[k] ← 0, rr_ptr ← (k+1) mod NCH.
  - LOAD: load_en is high for exactly this one cycle. Go to GAP.
  - GAP: load_en=0 and load_data is held. Go to IDLE.
  - Maximum commit rate is one channel per 3 cycles.
- **Round-robin.** The search starts at rr_ptr and ascends with wrap. The first eligible channel wins.
- **Write on the grant edge to the granted channel.**
  - The grant uses the old shadow value.
  - The new value is stored and pending stays 1.
  - No overrun is flagged.
  - The new value commits in the next safe window, or in the same window if cnt is still START when the FSM returns to IDLE.
- **Window lost before grant.** A channel that leaves START before it is granted stays pending and waits for the next rollover. It is never committed outside its window.
- **ovr_clear.** Clears all overrun bits. If ovr_clear coincides with an overrun-setting write, the set wins.
- **Scope.** The scheduler only presents data and strobes. Duty semantics (0 = always low, START+1 = always high) belong to the channel.

## Timing
- **Reset values.** shadows=0, pending=0, overrun=0, load_en=0, load_data=0, rr_ptr=0, state=IDLE, busy=0.
- **Reset mid-operation.** Reset asserted during LOAD drops load_en asynchronously. Discarded pending values are not replayed.
- **Latency.** Write at edge t makes pending visible after t. If the channel is already eligible and the FSM is IDLE, the grant edge is t+1, load_en is high during cycle t+1..t+2, and the channel captures on edge t+2.
- **Data validity.** load_data is stable from the grant edge through GAP.
- **busy.** Equals (state≠IDLE), registered.
- **Per-channel commit limit.** At most one commit per channel per LOAD. Multiple channels eligible in the same cycle are served in round-robin order at 3-cycle spacing.

## Test plan
- **Single commit.** Reset; cnt0=START; write ch0=0x1234. Expect load_en=0001 with load_data=0x1234 for exactly one cycle on the second edge after the write, then pending[0]=0 and overrun=0.
- **Wait for rollover.** cnt1=100; write ch1=0x0800. Expect no load_en while cnt1≠START. After cnt1 goes 0→START, expect a load within 2 cycles and pending[1]=0.
- **Round-robin fairness.** All 4 channels pending with cnt=START and rr_ptr=2. Expect grants ch2, ch3, ch0, ch1 at 3-cycle spacing, then busy=0.
- **Overrun.** cnt2≠START; write ch2=5 then ch2=9. Expect overrun[2]=1. At the window, expect load_data=9. ovr_clear → overrun=0.
- **Write on grant edge.** Write ch0=7 on ch0's grant edge while the old shadow is 3. Expect the load carries 3, pending[0] stays 1, the next load carries 7, and overrun=0.
- **Reset during LOAD.** Assert sysreset while load_en≠0. Expect load_en=0 immediately, and all outputs at their reset values.
